// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL reset, waits for lock with retry, and holds system reset until lock settles
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int TIMER_W       = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_loss,
  output logic [7:0] retry_count,
  output logic [1:0] state
);
  typedef enum logic [1:0] {RESET, WAIT_LOCK, SETTLE, RUN} state_t;
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
  state_t st, nxt;
  logic [TIMER_W-1:0] timer;
  logic sync1, locked_s, retry_inc;
  assign state = st;
  // bring the asynchronous lock indication into the refclk domain
  always_ff @(posedge refclk) begin
    sync1    <= rst ? 1'b0 : pll_locked;
    locked_s <= rst ? 1'b0 : sync1;
  end
  // next-state decode; lock beats timeout in WAIT_LOCK, stray encodings fall back to RESET
  always_comb begin
    nxt = RESET;
    case (st)
      RESET:     nxt = timer == RST_LAST ? WAIT_LOCK : RESET;
      WAIT_LOCK: nxt = locked_s ? SETTLE : (timer == LOCK_LAST ? RESET : WAIT_LOCK);
      SETTLE:    nxt = !locked_s ? WAIT_LOCK : (timer == SETTLE_LAST ? RUN : SETTLE);
      RUN:       nxt = locked_s ? RUN : RESET;
      default:   nxt = RESET;
    endcase
    retry_inc = (st == WAIT_LOCK || st == RUN) && nxt == RESET;
  end
  // state, timer, retry counter and outputs registered from the next state
  always_ff @(posedge refclk) begin
    if (rst) begin
      st          <= RESET;
      timer       <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_loss   <= 1'b0;
    end else begin
      st          <= nxt;
      timer       <= nxt != st ? '0 : timer + 1'b1;
      retry_count <= retry_inc && retry_count != 8'hff ? retry_count + 8'd1 : retry_count;
      pll_rst     <= nxt == RESET;
      sys_rst     <= nxt != RUN;
      ready       <= nxt == RUN;
      lock_loss   <= st == RUN && !locked_s;
    end
  end
endmodule
